// File: rtl/ipc_mcu_port.sv
// MCU-side access engine for the 512x8 IPC mailbox RAM: parses the SPI byte
// command stream (CMD, ADDR, LEN, data) into registered RAM reads/writes.
module ipc_mcu_port (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       CsActive,
  input  logic       RxValid,
  input  logic [7:0] RxData,
  input  logic       TxTake,
  output logic       TxValid,
  output logic [7:0] TxData,
  output logic [8:0] RamAddr,
  output logic [7:0] RamWData,
  output logic       RamWE,
  output logic       RamRE,
  input  logic [7:0] RamRData,
  output logic       Busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO,
    WRITE, READ_REQ, READ_CAP, READ_HOLD, DISCARD
  } stateT;

  stateT       state, stateNext;
  logic [8:0]  addr, addrNext;
  logic [9:0]  count, countNext;
  logic        isWrite, isWriteNext;
  logic        lenHi, lenHiNext;
  logic        txValidNext, ramWENext, ramRENext, busyNext;
  logic [7:0]  txDataNext, ramWDataNext;
  logic [8:0]  ramAddrNext;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      addr     <= '0;
      count    <= '0;
      isWrite  <= 1'b0;
      lenHi    <= 1'b0;
      TxValid  <= 1'b0;
      TxData   <= '0;
      RamAddr  <= '0;
      RamWData <= '0;
      RamWE    <= 1'b0;
      RamRE    <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      state    <= stateNext;
      addr     <= addrNext;
      count    <= countNext;
      isWrite  <= isWriteNext;
      lenHi    <= lenHiNext;
      TxValid  <= txValidNext;
      TxData   <= txDataNext;
      RamAddr  <= ramAddrNext;
      RamWData <= ramWDataNext;
      RamWE    <= ramWENext;
      RamRE    <= ramRENext;
      Busy     <= busyNext;
    end
  end

  // Every output is computed one cycle ahead here and registered above, so
  // strobes appear in the cycle after the triggering input was sampled.
  always_comb begin
    stateNext    = state;
    addrNext     = addr;
    countNext    = count;
    isWriteNext  = isWrite;
    lenHiNext    = lenHi;
    txValidNext  = TxValid;
    txDataNext   = TxData;
    ramAddrNext  = RamAddr;
    ramWDataNext = RamWData;
    ramWENext    = 1'b0;
    ramRENext    = 1'b0;

    if (!CsActive) begin
      stateNext   = IDLE;
      txValidNext = 1'b0;
    end else begin
      unique case (state)
        IDLE: if (RxValid) begin
          isWriteNext = (RxData == 8'h01);
          stateNext   = (RxData == 8'h01 || RxData == 8'h02) ? ADDR_HI : DISCARD;
        end
        ADDR_HI: if (RxValid) begin
          addrNext[8] = RxData[0];
          stateNext   = ADDR_LO;
        end
        ADDR_LO: if (RxValid) begin
          addrNext[7:0] = RxData;
          stateNext     = LEN_HI;
        end
        LEN_HI: if (RxValid) begin
          lenHiNext = RxData[0];
          stateNext = LEN_LO;
        end
        LEN_LO: if (RxValid) begin
          countNext = {1'b0, lenHi, RxData} + 10'd1;
          if (isWrite) begin
            stateNext = WRITE;
          end else begin
            stateNext   = READ_REQ;
            ramRENext   = 1'b1;
            ramAddrNext = addr;
          end
        end
        WRITE: if (RxValid) begin
          ramWENext    = 1'b1;
          ramAddrNext  = addr;
          ramWDataNext = RxData;
          addrNext     = addr + 9'd1;
          countNext    = count - 10'd1;
          if (count == 10'd1) stateNext = DISCARD;
        end
        READ_REQ: stateNext = READ_CAP;
        READ_CAP: begin
          txDataNext  = RamRData;
          txValidNext = 1'b1;
          addrNext    = addr + 9'd1;
          countNext   = count - 10'd1;
          stateNext   = READ_HOLD;
        end
        READ_HOLD: if (TxTake) begin
          txValidNext = 1'b0;
          if (count != 10'd0) begin
            stateNext   = READ_REQ;
            ramRENext   = 1'b1;
            ramAddrNext = addr;
          end else begin
            stateNext = DISCARD;
          end
        end
        DISCARD: stateNext = DISCARD;
        default: stateNext = IDLE;
      endcase
    end

    busyNext = (stateNext != IDLE);
  end

endmodule

// File: tb/tb_ipc_mcu_port.sv
// Directed bench for ipc_mcu_port: frame-level model predicts RAM writes/reads
// and read data; a per-cycle compare process checks the DUT against it.
module tb_ipc_mcu_port;

  logic       Clk, nReset, CsActive, RxValid, TxTake;
  logic [7:0] RxData, TxData, RamWData, RamRData;
  logic       TxValid, RamWE, RamRE, Busy;
  logic [8:0] RamAddr;

  ipc_mcu_port dut (
    .Clk(Clk), .nReset(nReset), .CsActive(CsActive), .RxValid(RxValid),
    .RxData(RxData), .TxTake(TxTake), .TxValid(TxValid), .TxData(TxData),
    .RamAddr(RamAddr), .RamWData(RamWData), .RamWE(RamWE), .RamRE(RamRE),
    .RamRData(RamRData), .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Bench-side IPC RAM (synchronous, one-cycle read latency)
  logic [7:0] ram [512];
  always @(posedge Clk) begin
    if (RamWE) ram[RamAddr] <= RamWData;
    if (RamRE) RamRData <= ram[RamAddr];
  end

  int nCmp = 0;
  int nErr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model state
  logic [7:0]  refMem [512];
  logic [16:0] expWr[$];
  logic [8:0]  expRdAddr[$];
  logic [7:0]  expRdData[$];
  logic [16:0] wrLog[$];
  int          rePulses;
  logic        mBusy;
  logic        txSeen;
  logic [7:0]  fr[$];

  // Busy: set by the first byte of an active frame, cleared when the frame ends
  always @(posedge Clk or negedge nReset) begin
    if (!nReset) mBusy <= 1'b0;
    else         mBusy <= CsActive && (mBusy || RxValid);
  end

  always @(negedge Clk) begin
    if (!nReset) begin
      txSeen = 1'b0;
      expWr.delete();
      expRdAddr.delete();
      expRdData.delete();
    end else begin
      chk("busy", {31'd0, Busy}, {31'd0, mBusy});
      if (RamWE || RamRE) chk("strobeExcl", {31'd0, RamWE && RamRE}, 32'd0);
      if (RamWE) begin
        wrLog.push_back({RamAddr, RamWData});
        chk("wrExpected", {31'd0, expWr.size() > 0}, 32'd1);
        if (expWr.size() > 0) chk("wrAddrData", {15'd0, RamAddr, RamWData}, {15'd0, expWr.pop_front()});
      end
      if (RamRE) begin
        rePulses++;
        chk("rdExpected", {31'd0, expRdAddr.size() > 0}, 32'd1);
        if (expRdAddr.size() > 0) chk("rdAddr", {23'd0, RamAddr}, {23'd0, expRdAddr.pop_front()});
      end
      if (TxValid && !txSeen) begin
        chk("txExpected", {31'd0, expRdData.size() > 0}, 32'd1);
        if (expRdData.size() > 0) chk("txData", {24'd0, TxData}, {24'd0, expRdData.pop_front()});
      end
      txSeen = TxValid;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Predict effects of frame fr, then send it back-to-back. With abortLast the
  // final byte coincides with CsActive low and must be dropped.
  task automatic sendFrame(input bit abortLast);
    logic [8:0]  start;
    logic [8:0]  a;
    int unsigned n, nData;
    start = {fr[1][0], fr[2]};
    n     = int'({fr[3][0], fr[4]}) + 1;
    nData = fr.size() - 5 - (abortLast ? 1 : 0);
    if (fr[0] == 8'h01) begin
      for (int unsigned i = 0; i < nData && i < n; i++) begin
        a = 9'((int'(start) + int'(i)) % 512);
        expWr.push_back({a, fr[5 + i]});
        refMem[a] = fr[5 + i];
      end
    end else if (fr[0] == 8'h02) begin
      for (int unsigned i = 0; i < n; i++) begin
        a = 9'((int'(start) + int'(i)) % 512);
        expRdAddr.push_back(a);
        expRdData.push_back(refMem[a]);
      end
    end
    for (int unsigned i = 0; i < fr.size(); i++) begin
      RxValid = 1'b1;
      RxData  = fr[i];
      if (abortLast && i == fr.size() - 1) CsActive = 1'b0;
      tick();
    end
    RxValid = 1'b0;
  endtask

  task automatic endFrame();
    CsActive = 1'b0;
    tick();
    chk("endBusy", {31'd0, Busy}, 32'd0);
    chk("endTxValid", {31'd0, TxValid}, 32'd0);
    CsActive = 1'b1;
    tick();
  endtask

  task automatic take();
    TxTake = 1'b1;
    tick();
    TxTake = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    nReset = 1'b1; CsActive = 1'b0; RxValid = 1'b0; RxData = '0; TxTake = 1'b0;
    rePulses = 0;
    #2 nReset = 1'b0;
    #1;
    chk("rstTxValid", {31'd0, TxValid}, 32'd0);
    chk("rstTxData", {24'd0, TxData}, 32'd0);
    chk("rstRamAddr", {23'd0, RamAddr}, 32'd0);
    chk("rstRamWData", {24'd0, RamWData}, 32'd0);
    chk("rstStrobes", {30'd0, RamWE, RamRE}, 32'd0);
    chk("rstBusy", {31'd0, Busy}, 32'd0);
    tick(); tick();
    nReset = 1'b1;
    tick();
    CsActive = 1'b1;
    tick();

    // Basic 3-byte write
    wrLog.delete();
    fr = '{8'h01, 8'h00, 8'h10, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC};
    sendFrame(1'b0);
    repeat (3) tick();
    chk("wrBusyHeld", {31'd0, Busy}, 32'd1);
    chk("wrCount", wrLog.size(), 32'd3);
    if (wrLog.size() == 3) begin
      chk("wr0", {15'd0, wrLog[0]}, {15'd0, 9'h010, 8'hAA});
      chk("wr1", {15'd0, wrLog[1]}, {15'd0, 9'h011, 8'hBB});
      chk("wr2", {15'd0, wrLog[2]}, {15'd0, 9'h012, 8'hCC});
    end
    endFrame();

    // Wrap-around write with a trailing surplus byte
    wrLog.delete();
    fr = '{8'h01, 8'h01, 8'hFF, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33};
    sendFrame(1'b0);
    tick();
    chk("wrapCount", wrLog.size(), 32'd2);
    if (wrLog.size() == 2) begin
      chk("wrap0", {15'd0, wrLog[0]}, {15'd0, 9'h1FF, 8'h11});
      chk("wrap1", {15'd0, wrLog[1]}, {15'd0, 9'h000, 8'h22});
    end
    endFrame();

    // Preload 0x020/0x021, then read them back
    fr = '{8'h01, 8'h00, 8'h20, 8'h00, 8'h01, 8'h5A, 8'hA5};
    sendFrame(1'b0);
    endFrame();
    rePulses = 0;
    fr = '{8'h02, 8'h00, 8'h20, 8'h00, 8'h01};
    sendFrame(1'b0);
    chk("rdReqLat", {31'd0, RamRE}, 32'd1);
    chk("rdReqAddr", {23'd0, RamAddr}, 32'h020);
    tick();
    chk("rdCapLat", {31'd0, TxValid}, 32'd0);
    tick();
    chk("rdValidLat", {31'd0, TxValid}, 32'd1);
    chk("rdData0", {24'd0, TxData}, 32'h5A);
    take();
    chk("refillClr", {31'd0, TxValid}, 32'd0);
    chk("refillReq", {31'd0, RamRE}, 32'd1);
    tick(); tick();
    chk("refillValid", {31'd0, TxValid}, 32'd1);
    chk("rdData1", {24'd0, TxData}, 32'hA5);
    take();
    chk("lastClr", {31'd0, TxValid}, 32'd0);
    repeat (4) tick();
    chk("rdPulses", rePulses, 32'd2);
    endFrame();

    // Abort: frame end coincides with the 3rd data byte of a 4-byte write
    wrLog.delete();
    fr = '{8'h01, 8'h00, 8'h40, 8'h00, 8'h03, 8'hD0, 8'hD1, 8'hD2};
    sendFrame(1'b1);
    chk("abortBusy", {31'd0, Busy}, 32'd0);
    tick();
    chk("abortCount", wrLog.size(), 32'd2);
    CsActive = 1'b1;
    tick();
    fr = '{8'h02, 8'h00, 8'h40, 8'h00, 8'h00};
    sendFrame(1'b0);
    tick(); tick();
    chk("postAbortRd", {23'd0, TxValid, TxData}, {23'd0, 1'b1, 8'hD0});
    take();
    endFrame();

    // Unknown command
    wrLog.delete();
    rePulses = 0;
    fr = '{8'h7F, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    sendFrame(1'b0);
    tick();
    chk("badBusy", {31'd0, Busy}, 32'd1);
    chk("badStrobes", wrLog.size() + rePulses, 32'd0);
    chk("badTxValid", {31'd0, TxValid}, 32'd0);
    endFrame();

    // Async reset in the middle of a read with TxValid high
    fr = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 8'h3C, 8'hC3};
    sendFrame(1'b0);
    endFrame();
    fr = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h01};
    sendFrame(1'b0);
    tick(); tick();
    chk("preRstRd", {23'd0, TxValid, TxData}, {23'd0, 1'b1, 8'h3C});
    #2 nReset = 1'b0;
    #1;
    chk("asyncTx", {23'd0, TxValid, TxData}, 32'd0);
    chk("asyncRam", {15'd0, RamAddr, RamWData}, 32'd0);
    chk("asyncStrobes", {29'd0, RamWE, RamRE, Busy}, 32'd0);
    CsActive = 1'b0;
    tick();
    nReset = 1'b1;
    tick();
    CsActive = 1'b1;
    repeat (3) tick();

    chk("wrQueueDrained", expWr.size(), 32'd0);
    chk("rdQueueDrained", expRdAddr.size() + expRdData.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/ipc_mcu_port.md
# ipc_mcu_port

MCU-side access engine for the 512-byte IPC RAM shared with the cartridge bus. It parses a byte-stream command protocol delivered by the SPI slave byte layer and turns it into synchronous reads and writes on the IPC RAM's second port. The console side accesses the same RAM through its nOE/nWE strobes. This block is the MCU's end of that mailbox, running entirely in the FPGA system clock domain.

## Interface
- No parameters. RAM depth is fixed at 512 × 8 and addresses are 9 bits.
- Clk  in  1  system clock; all logic is on its rising edge.
- nReset  in  1  asynchronous, active-low reset.
- CsActive  in  1  SPI frame active. Low means frame ended; it forces IDLE from any state.
- RxValid  in  1  one-cycle pulse indicating a received byte on RxData.
- RxData  in  8  received byte.
- TxTake  in  1  one-cycle pulse: SPI layer consumed TxData.
- TxValid  out  1  TxData holds an unconsumed read byte.
- TxData  out  8  read byte for the SPI shifter.
- RamAddr  out  9  IPC RAM port address.
- RamWData  out  8  IPC RAM write data.
- RamWE  out  1  write strobe, one cycle per byte.
- RamRE  out  1  read strobe; RamRData is valid the cycle after.
- RamRData  in  8  IPC RAM read data.
- Busy  out  1  high in any state other than IDLE.

## Operation
- Frame layout: CMD, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, then data.
- Start address = {ADDR_HI[0], ADDR_LO}. ADDR_HI[7:1] is ignored.
- Byte count N = {LEN_HI[0], LEN_LO} + 1, giving a range of 1..512.
- Command codes: CMD 0x01 = write, 0x02 = read. Any other value goes to DISCARD.
- FSM states: IDLE → ADDR_HI → ADDR_LO → LEN_HI → LEN_LO → WRITE or READ_REQ.
  - Read path loops READ_REQ → READ_CAP → READ_HOLD.
  - Both paths end in DISCARD once N bytes are done.
  - Every header state advances on RxValid only.
- WRITE state:
  - Each RxValid issues RamWE with the current address and RxData.
  - Address then increments modulo 512 (0x1FF wraps to 0x000) and the remaining count decrements.
  - After the Nth byte, go to DISCARD.
- READ path:
  - READ_REQ asserts RamRE at the current address.
  - READ_CAP latches RamRData into TxData, sets TxValid, advances the address modulo 512 and decrements the count.
  - READ_HOLD waits for TxTake. TxTake clears TxValid, then goes to READ_REQ if bytes remain, else to DISCARD.
  - RxValid bytes received during a read are ignored.
- DISCARD ignores all input until the frame ends.
- CsActive low, in any state:
  - Next state is IDLE and TxValid clears.
  - An in-flight read result is dropped.
  - Writes already strobed stay committed.
- CsActive low together with RxValid in the same cycle: frame end wins and the byte is dropped.
- TxTake while TxValid = 0 is ignored.
- At most one RAM strobe is asserted per cycle. RamWE and RamRE are never high together.

## Timing
- Reset values:
  - TxValid = 0, TxData = 0x00.
  - RamAddr = 0, RamWData = 0x00, RamWE = 0, RamRE = 0.
  - Busy = 0, state = IDLE.
- All outputs are registered.
- Write latency: RxValid sampled at edge E → RamWE, RamAddr and RamWData valid in the cycle after E, for exactly one cycle.
- Read latency:
  - LEN_LO sampled at edge E → RamRE high after E.
  - RamRData is captured at E+2 → TxValid high after E+2.
- Read refill: TxTake sampled at edge T → TxValid low after T, RamRE high after T, TxValid high again after T+2.
- Back-to-back RxValid on consecutive cycles must be accepted in every state, giving one write per cycle.
- CsActive low sampled at edge E → Busy = 0 and TxValid = 0 after E. No RAM strobe follows E.
- Reset asserted mid-transfer returns all outputs to their reset values immediately (asynchronous).

## Test plan
- Write: bytes 01 00 10 00 02 AA BB CC → RamWE pulses at addresses 0x010, 0x011, 0x012 with data AA, BB, CC. Busy stays high until CsActive drops.
- Wrap-around write: 01 01 FF 00 01 11 22 → writes 0x1FF = 11 and 0x000 = 22. A trailing byte 33 produces no RamWE.
- Read: preload 0x020 = 5A and 0x021 = A5, send 02 00 20 00 01 → TxData 5A with TxValid two cycles after LEN_LO. After TxTake, TxData becomes A5. After the second TxTake, no further RamRE.
- Abort: CsActive drops in the same cycle as the 3rd data byte of a 4-byte write → only 2 RamWE pulses, and Busy = 0 next cycle. A new read frame then works normally.
- Bad command 0x7F followed by 6 bytes → no RamWE or RamRE, TxValid stays 0. IDLE is reached after CsActive drops.
- Async reset asserted mid-read with TxValid = 1 → all outputs 0 immediately, with no clock edge required.
